// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_SAT_EN to load all-nines into bcd when the result overflows.
module bin2bcd_seq #(
    parameter int N_BITS   = 8,
    parameter int N_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_BITS-1:0]     bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] bcd,
    output logic                  overflow
);
    localparam int W  = 4 * N_DIGITS;
    localparam int CW = $clog2(N_BITS + 1);
    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    logic              state;
    logic [N_BITS-1:0] sreg;
    logic [W-1:0]      scratch, adj, nxt, res;
    logic [CW-1:0]     cnt;
    logic              sticky, lost, last;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < N_DIGITS; i++)
            adj[4*i +: 4] = scratch[4*i +: 4] >= 4'd5 ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
    end

    // The adjusted top-digit MSB is exactly the bit pushed out of the scratch digits.
    assign nxt  = {adj[W-2:0], sreg[N_BITS-1]};
    assign lost = adj[W-1];
    assign last = cnt == CW'(N_BITS - 1);
    assign busy = state == SHIFT;

`ifdef BIN2BCD_SAT_EN
    assign res = (sticky | lost) ? {N_DIGITS{4'h9}} : nxt;
`else
    assign res = nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            scratch  <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sreg    <= bin;
                    scratch <= '0;
                    cnt     <= '0;
                    sticky  <= 1'b0;
                    state   <= SHIFT;
                end
            end else begin
                scratch <= nxt;
                sreg    <= sreg << 1;
                cnt     <= cnt + 1'b1;
                sticky  <= sticky | lost;
                if (last) begin
                    bcd      <= res;
                    overflow <= sticky | lost;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and exhaustive checks of bin2bcd_seq with 3-digit and 2-digit instances.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start3 = 1'b0, start2 = 1'b0;
    logic [7:0]  bin3 = '0, bin2 = '0;
    logic        busy3, done3, ovf3, busy2, done2, ovf2;
    logic [11:0] bcd3;
    logic [7:0]  bcd2;
    int          n_cmp = 0, n_err = 0, nd3 = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.N_BITS(8), .N_DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .bin(bin3),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
    );

    bin2bcd_seq #(.N_BITS(8), .N_DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
    );

    always @(posedge clk) if (done3) nd3 <= nd3 + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic conv3(input logic [7:0] b, input logic [11:0] exp);
        bin3 = b; start3 = 1'b1;
        step(1);
        start3 = 1'b0;
        step(8);
        chk("c3_done", done3, 1);
        chk("c3_bcd", bcd3, exp);
        chk("c3_ovf", ovf3, 0);
    endtask

    task automatic conv2(input logic [7:0] b, input logic [7:0] exp, input logic exp_ovf);
        bin2 = b; start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        step(8);
        chk("c2_done", done2, 1);
        chk("c2_bcd", bcd2, exp);
        chk("c2_ovf", ovf2, exp_ovf);
    endtask

    initial begin
        int d0;
        logic [11:0] e;
        step(2);
        chk("rst_busy", busy3, 0);
        chk("rst_done", done3, 0);
        chk("rst_bcd", bcd3, 0);
        chk("rst_ovf", ovf3, 0);
        rst = 1'b0;
        step(1);

        // 255 with full latency profile
        bin3 = 8'd255; start3 = 1'b1;
        step(1);
        start3 = 1'b0;
        chk("t1_busy_acc", busy3, 1);
        step(7);
        chk("t1_done_early", done3, 0);
        chk("t1_busy_mid", busy3, 1);
        step(1);
        chk("t1_done", done3, 1);
        chk("t1_bcd", bcd3, 12'h255);
        chk("t1_ovf", ovf3, 0);
        chk("t1_busy_end", busy3, 0);
        step(1);
        chk("t1_done_pulse", done3, 0);
        chk("t1_bcd_hold", bcd3, 12'h255);

        // back-to-back with start held high
        bin3 = 8'd0; start3 = 1'b1;
        step(9);
        chk("b2b_done0", done3, 1);
        chk("b2b_bcd0", bcd3, 12'h000);
        bin3 = 8'd9;
        step(1);
        chk("b2b_busy1", busy3, 1);
        step(8);
        chk("b2b_done1", done3, 1);
        chk("b2b_bcd1", bcd3, 12'h009);
        bin3 = 8'd10;
        step(9);
        chk("b2b_done2", done3, 1);
        chk("b2b_bcd2", bcd3, 12'h010);
        start3 = 1'b0;
        step(1);

        // 2-digit overflow and boundary
`ifdef BIN2BCD_SAT_EN
        conv2(8'd123, 8'h99, 1'b1);
        conv2(8'd100, 8'h99, 1'b1);
`else
        conv2(8'd123, 8'h23, 1'b1);
        conv2(8'd100, 8'h00, 1'b1);
`endif
        conv2(8'd99, 8'h99, 1'b0);

        // start while busy is ignored
        bin3 = 8'd200; start3 = 1'b1;
        step(1);
        start3 = 1'b0;
        step(2);
        bin3 = 8'd7; start3 = 1'b1;
        step(1);
        start3 = 1'b0;
        step(5);
        chk("ign_done", done3, 1);
        chk("ign_bcd", bcd3, 12'h200);
        d0 = nd3;
        step(10);
        chk("ign_ndone", nd3, d0 + 1);
        chk("ign_bcd_hold", bcd3, 12'h200);

        // asynchronous reset mid-conversion
        bin3 = 8'd77; start3 = 1'b1;
        step(1);
        start3 = 1'b0;
        step(4);
        rst = 1'b1;
        #1;
        chk("ar_busy", busy3, 0);
        chk("ar_bcd", bcd3, 0);
        chk("ar_done", done3, 0);
        chk("ar_ovf", ovf3, 0);
        d0 = nd3;
        step(2);
        rst = 1'b0;
        step(10);
        chk("ar_nodone", nd3, d0);
        conv3(8'd77, 12'h077);
        step(1);

        // exhaustive sweep against decimal reference
        d0 = nd3;
        for (int v = 0; v < 256; v++) begin
            e = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            conv3(8'(v), e);
        end
        step(1);
        chk("sweep_ndone", nd3, d0 + 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the multi-digit BCD adder and converts binary operands into packed BCD operands for it.
- Start/done handshake. One conversion in flight at a time.

Parameters:
- N_BITS, 8: width of the binary input; must be >= 1.
- N_DIGITS, 3: number of BCD output digits; output width is 4*N_DIGITS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  N_BITS  binary operand; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: bcd/overflow just updated.
- bcd  output  4*N_DIGITS  packed BCD result; digit 0 in [3:0].
- overflow  output  1  result did not fit in N_DIGITS digits.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, bcd=0, overflow=0; internal shift register, scratch digits, bit counter and sticky overflow all cleared. Reset mid-conversion aborts it with no done pulse.
- States:
  - IDLE: busy=0. If start=1 at edge k: load bin into the shift register, scratch=0, counter=0, sticky ovf=0, go to SHIFT, busy=1 after edge k. If start=0: stay in IDLE.
  - SHIFT: on each edge, every scratch digit >= 5 gets +3, then {scratch, shiftreg} shifts left by 1 and counter increments.
  - Bit shifted out of the top digit:
    - If it is 1, set sticky ovf.
    - If the top digit is >= 8 before the shift, that also sets sticky ovf.
    - Any nonzero bit lost counts.
  - On the N_BITS-th shift (edge k+N_BITS), register the shifted scratch into bcd, register sticky ovf (including this shift) into overflow, set done=1, clear busy, go to IDLE.
- Latency: start accepted at edge k, so done is high during the cycle after edge k+N_BITS. Throughput is one result per N_BITS+1 cycles.
- done: high exactly one cycle; cleared on the next edge.
- start while busy is ignored; no queuing.
- start=1 in the cycle done=1 is accepted; this is back-to-back operation. bcd/overflow keep the just-finished result until the next completion.
- bin changes after the accepting edge do not affect the conversion in flight.
- bcd and overflow hold their value between conversions. They change only on a completing edge or on reset.
- Without saturation, low digits are always exact: bcd = bin mod 10^N_DIGITS, in BCD.
- Every digit of bcd is always in 0..9.
- Counter width: clog2(N_BITS+1).

Optional Feature:
- Macro BIN2BCD_SAT_EN.
- Defined: on a completing edge with overflow=1, bcd is loaded with all digits = 9 instead of the truncated value. overflow still asserts.
- Undefined: bcd is loaded with the truncated low N_DIGITS digits. Saturation logic is absent.

Test Plan:
- N_BITS=8, N_DIGITS=3, bin=8'd255, start pulse at edge 0 -> busy=1 from edge 0, done pulse after edge 8, bcd=12'h255, overflow=0.
- bin=8'd0, then bin=8'd9, then bin=8'd10, issued back-to-back with start held high -> done pulses 9 cycles apart; bcd=12'h000, 12'h009, 12'h010.
- N_DIGITS=2, bin=8'd123 -> overflow=1; bcd=8'h23 without BIN2BCD_SAT_EN, 8'h99 with it. bin=8'd99 -> bcd=8'h99, overflow=0.
- Start with bin=8'd200, then at edge 3 pulse start with bin=8'd7 -> second request ignored; bcd=12'h200 after edge 8; no second done.
- Start with bin=8'd77, assert rst at edge 4 -> all outputs 0 immediately (asynchronous); no done pulse. New start after reset release with bin=8'd77 -> bcd=12'h077.
- Exhaustive bin 0..255 compared against a reference model (bin/100, bin/10%10, bin%10) -> all match. done count = 256.
